// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer for the shared DataMemory: two requesters,
// one single-cycle command at a time, read data returned with a per-port valid pulse.
module dmem_arbiter #(
    parameter int RD_LAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic       we0,
    input  logic       we1,
    input  logic [7:0] addr0,
    input  logic [7:0] addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       rvalid0,
    output logic       rvalid1,
    output logic [7:0] rdata,
    output logic       busy,
    output logic [7:0] adr,
    output logic [7:0] datain,
    output logic       w,
    output logic       r,
    input  logic [7:0] dataout
);

    typedef enum logic [1:0] {IDLE, CMD, RWAIT, RESP} state_t;

    localparam logic [1:0] LAT2 = 2'(RD_LAT);

    state_t     state, state_nxt;
    logic       last;
    logic       port_q;
    logic       we_q;
    logic [1:0] cnt;
    logic [7:0] adr_q, din_q, rdata_q;
    logic       any_req, win, win_we, capture;

    // On a tie the port that did not win last time gets the grant.
    always_comb begin
        any_req = req0 | req1;
        win     = (req0 & req1) ? ~last : req1;
        win_we  = win ? we1 : we0;
        capture = ((state == CMD) && !we_q && (RD_LAT == 0)) ||
                  ((state == RWAIT) && (cnt == 2'd1));
    end

    always_comb begin
        state_nxt = state;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        rvalid0   = 1'b0;
        rvalid1   = 1'b0;
        w         = 1'b0;
        r         = 1'b0;
        case (state)
            IDLE: if (any_req) state_nxt = CMD;
            CMD: begin
                gnt0 = ~port_q;
                gnt1 = port_q;
                w    = we_q;
                r    = ~we_q;
                if (we_q)             state_nxt = IDLE;
                else if (RD_LAT == 0) state_nxt = RESP;
                else                  state_nxt = RWAIT;
            end
            RWAIT: if (cnt == 2'd1) state_nxt = RESP;
            RESP: begin
                rvalid0   = ~port_q;
                rvalid1   = port_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            last    <= 1'b1;
            cnt     <= 2'd0;
            port_q  <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= 8'h00;
            din_q   <= 8'h00;
            rdata_q <= 8'h00;
        end else begin
            state <= state_nxt;
            if (state == IDLE && any_req) begin
                port_q <= win;
                last   <= win;
                we_q   <= win_we;
                adr_q  <= win ? addr1 : addr0;
                // datain only moves for writes so it holds across reads
                if (win_we) din_q <= win ? wdata1 : wdata0;
            end
            if (state == CMD)   cnt <= LAT2;
            if (state == RWAIT) cnt <= cnt - 2'd1;
            if (capture)        rdata_q <= dataout;
        end
    end

    assign busy   = (state != IDLE);
    assign adr    = adr_q;
    assign datain = din_q;
    assign rdata  = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: three instances (RD_LAT 1, 0, 3) each with a memory
// model; directed scenarios plus randomized accesses checked against a reference memory.
module tb_dmem_arbiter;

    localparam int NI = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic [NI-1:0] req0, req1, we0, we1, gnt0, gnt1, rvalid0, rvalid1, busy, w, r;
    logic [7:0] addr0 [NI];
    logic [7:0] addr1 [NI];
    logic [7:0] wdata0 [NI];
    logic [7:0] wdata1 [NI];
    logic [7:0] rdata [NI];
    logic [7:0] adr [NI];
    logic [7:0] datain [NI];
    logic [7:0] dataout [NI];

    int vectors = 0;
    int miscompares = 0;
    int lat_of [NI] = '{1, 0, 3};
    logic last_exp [NI];
    logic [7:0] ref_mem [NI][256];

    always #5 clk = ~clk;

    for (genvar k = 0; k < NI; k++) begin : g
        localparam int L = (k == 0) ? 1 : (k == 1) ? 0 : 3;
        logic [7:0] mem [256];
        logic [7:0] pipe [4];

        initial for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        dmem_arbiter #(.RD_LAT(L)) dut (
            .clk(clk), .rst_n(rst_n),
            .req0(req0[k]), .req1(req1[k]), .we0(we0[k]), .we1(we1[k]),
            .addr0(addr0[k]), .addr1(addr1[k]), .wdata0(wdata0[k]), .wdata1(wdata1[k]),
            .gnt0(gnt0[k]), .gnt1(gnt1[k]), .rvalid0(rvalid0[k]), .rvalid1(rvalid1[k]),
            .rdata(rdata[k]), .busy(busy[k]), .adr(adr[k]), .datain(datain[k]),
            .w(w[k]), .r(r[k]), .dataout(dataout[k])
        );

        // Data is only meaningful exactly L cycles after r; otherwise a sentinel.
        always @(posedge clk) begin
            if (w[k]) mem[adr[k]] <= datain[k];
            pipe[0] <= r[k] ? mem[adr[k]] : 8'hEE;
            for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
        end

        if (L == 0) begin : comb_rd
            assign dataout[k] = r[k] ? mem[adr[k]] : 8'hEE;
        end else begin : pipe_rd
            assign dataout[k] = pipe[(L == 0) ? 0 : L - 1];
        end
    end

    // Cycle-wise invariants on every instance
    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            vectors++;
            assert ((w[k] & r[k]) === 1'b0)
            else begin miscompares++; $error("FAIL inv_wr k=%0d observed=%b expected=0", k, w[k] & r[k]); end
            vectors++;
            assert (((gnt0[k] & gnt1[k]) | (rvalid0[k] & rvalid1[k])) === 1'b0)
            else begin miscompares++; $error("FAIL inv_onehot k=%0d observed=1 expected=0", k); end
            vectors++;
            assert ((gnt0[k] | gnt1[k]) === (w[k] | r[k]))
            else begin miscompares++; $error("FAIL inv_gnt_cmd k=%0d observed=%b expected=%b", k, gnt0[k] | gnt1[k], w[k] | r[k]); end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int k, input logic p, input logic v, input logic we,
                           input logic [7:0] a, input logic [7:0] d);
        if (!p) begin req0[k] = v; we0[k] = we; addr0[k] = a; wdata0[k] = d; end
        else    begin req1[k] = v; we1[k] = we; addr1[k] = a; wdata1[k] = d; end
    endtask

    function automatic logic g_gnt(input int k, input logic p);
        return p ? gnt1[k] : gnt0[k];
    endfunction

    function automatic logic g_rv(input int k, input logic p);
        return p ? rvalid1[k] : rvalid0[k];
    endfunction

    task automatic check_reset_outputs(input string tag);
        for (int k = 0; k < NI; k++) begin
            check({tag, "_ctl"}, {gnt0[k], gnt1[k], rvalid0[k], rvalid1[k], busy[k], w[k], r[k], 1'b0}, 8'h00);
            check({tag, "_rdata"}, rdata[k], 8'h00);
            check({tag, "_adr"}, adr[k], 8'h00);
            check({tag, "_datain"}, datain[k], 8'h00);
        end
    endtask

    // Single access from IDLE: grant next cycle, read valid RD_LAT+1 cycles after grant.
    task automatic access(input int k, input logic p, input logic we,
                          input logic [7:0] a, input logic [7:0] d);
        int n;
        set_req(k, p, 1'b1, we, a, d);
        n = 0;
        do begin tick(); n++; end while (!g_gnt(k, p) && n < 8);
        check("gnt_latency", 8'(n), 8'd1);
        set_req(k, p, 1'b0, we, a, d);
        last_exp[k] = p;
        check("cmd_w", {7'd0, w[k]}, {7'd0, we});
        check("cmd_r", {7'd0, r[k]}, {7'd0, !we});
        check("cmd_adr", adr[k], a);
        if (we) begin
            check("cmd_datain", datain[k], d);
            ref_mem[k][a] = d;
            tick();
            check("wr_idle", {7'd0, busy[k]}, 8'd0);
        end else begin
            n = 0;
            do begin tick(); n++; end while (!g_rv(k, p) && n < 8);
            check("rvalid_latency", 8'(n), 8'(lat_of[k] + 1));
            check("rdata", rdata[k], ref_mem[k][a]);
            check("rvalid_other", {7'd0, g_rv(k, !p)}, 8'd0);
            tick();
            check("rd_idle", {7'd0, busy[k]}, 8'd0);
        end
    endtask

    // Both ports request writes in the same cycle and hold until granted.
    task automatic tie_writes(input int k, input logic [7:0] a0, input logic [7:0] d0,
                              input logic [7:0] a1, input logic [7:0] d1);
        logic win;
        logic [7:0] la, ld;
        win = !last_exp[k];
        la  = win ? a0 : a1;
        ld  = win ? d0 : d1;
        set_req(k, 1'b0, 1'b1, 1'b1, a0, d0);
        set_req(k, 1'b1, 1'b1, 1'b1, a1, d1);
        tick();
        check("tie_first_gnt", {6'd0, gnt1[k], gnt0[k]}, win ? 8'd2 : 8'd1);
        check("tie_first_adr", adr[k], win ? a1 : a0);
        set_req(k, win, 1'b0, 1'b1, win ? a1 : a0, win ? d1 : d0);
        ref_mem[k][win ? a1 : a0] = win ? d1 : d0;
        last_exp[k] = win;
        tick();
        check("tie_gap", {6'd0, gnt1[k], gnt0[k]}, 8'd0);
        check("tie_gap_busy", {7'd0, busy[k]}, 8'd0);
        tick();
        check("tie_second_gnt", {6'd0, gnt1[k], gnt0[k]}, win ? 8'd1 : 8'd2);
        check("tie_second_adr", adr[k], la);
        check("tie_second_datain", datain[k], ld);
        set_req(k, !win, 1'b0, 1'b1, la, ld);
        ref_mem[k][la] = ld;
        last_exp[k] = !win;
        tick();
        check("tie_idle", {7'd0, busy[k]}, 8'd0);
    endtask

    initial begin
        logic [7:0] a, d;
        for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < 256; i++) ref_mem[k][i] = 8'h00;
            set_req(k, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
            set_req(k, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        end

        // Reset with random inputs and both ports requesting
        rst_n = 1'b0;
        for (int c = 0; c < 2; c++) begin
            for (int k = 0; k < NI; k++) begin
                set_req(k, 1'b0, 1'b1, 1'($urandom), 8'($urandom), 8'($urandom));
                set_req(k, 1'b1, 1'b1, 1'($urandom), 8'($urandom), 8'($urandom));
            end
            tick();
            check_reset_outputs("reset");
        end
        for (int k = 0; k < NI; k++) begin
            set_req(k, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
            set_req(k, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
            last_exp[k] = 1'b1;
        end
        rst_n = 1'b1;
        tick();

        // First tie after reset goes to port 0; readback both
        tie_writes(0, 8'h00, 8'h55, 8'h01, 8'h11);
        access(0, 1'b0, 1'b0, 8'h00, 8'h00);
        access(0, 1'b1, 1'b0, 8'h01, 8'h00);
        check("readback_0x01", rdata[0], 8'h11);

        // Port 0 write then read of 0x0A
        access(0, 1'b0, 1'b1, 8'h0A, 8'hFF);
        access(0, 1'b0, 1'b0, 8'h0A, 8'h00);
        check("readback_0x0A", rdata[0], 8'hFF);

        // req0 rises while port 1 read sits in RWAIT
        set_req(0, 1'b1, 1'b1, 1'b0, 8'h01, 8'h00);
        tick();
        check("p1_gnt", {6'd0, gnt1[0], gnt0[0]}, 8'd2);
        set_req(0, 1'b1, 1'b0, 1'b0, 8'h01, 8'h00);
        tick();
        set_req(0, 1'b0, 1'b1, 1'b0, 8'h0A, 8'h00);
        tick();
        check("p1_rvalid", {5'd0, gnt0[0], rvalid1[0], rvalid0[0]}, 8'd2);
        check("p1_rdata", rdata[0], 8'h11);
        tick();
        check("p0_wait_idle", {6'd0, gnt0[0], busy[0]}, 8'd0);
        tick();
        check("p0_gnt_after", {7'd0, gnt0[0]}, 8'd1);
        set_req(0, 1'b0, 1'b0, 1'b0, 8'h0A, 8'h00);
        tick();
        tick();
        check("p0_rvalid", {7'd0, rvalid0[0]}, 8'd1);
        check("p0_rdata", rdata[0], 8'hFF);
        tick();

        // Reset during RWAIT of a port 0 read aborts it
        set_req(0, 1'b0, 1'b1, 1'b0, 8'h0A, 8'h00);
        tick();
        set_req(0, 1'b0, 1'b0, 1'b0, 8'h0A, 8'h00);
        tick();
        rst_n = 1'b0;
        tick();
        check_reset_outputs("abort");
        rst_n = 1'b1;
        for (int k = 0; k < NI; k++) last_exp[k] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("abort_no_rvalid", {6'd0, rvalid1[0], rvalid0[0]}, 8'd0);
        end
        tie_writes(0, 8'h20, 8'hA5, 8'h21, 8'h5A);

        // Latency sweep: preload 0x3C, read it back at RD_LAT 0 and 3
        access(1, 1'b0, 1'b1, 8'h40, 8'h3C);
        access(1, 1'b1, 1'b0, 8'h40, 8'h00);
        check("lat0_rdata", rdata[1], 8'h3C);
        access(2, 1'b1, 1'b1, 8'h41, 8'h3C);
        access(2, 1'b0, 1'b0, 8'h41, 8'h00);
        check("lat3_rdata", rdata[2], 8'h3C);

        // Randomized single accesses and ties across all instances
        for (int i = 0; i < 60; i++) begin
            int k;
            k = int'($urandom_range(0, NI - 1));
            a = 8'($urandom_range(0, 15));
            d = 8'($urandom);
            if ($urandom_range(0, 4) == 0)
                tie_writes(k, a, d, 8'(a + 8'd16), 8'($urandom));
            else
                access(k, 1'($urandom), 1'($urandom), a, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer for the shared `DataMemory` (8-bit address, 8-bit data).
- It accepts load/store requests from two requesters, the core port (0) and the DMA/debug port (1), and selects one round-robin.
- It drives the memory's `adr`, `datain`, `w` and `r` for exactly one command cycle, then returns read data with a per-port valid pulse.
- It sits between the requesters and the `DataMemory` instance and is the only driver of the memory's command inputs.

## Interface
Parameters:
- `RD_LAT`, default 1: memory read latency in cycles, legal range 0..3. `dataout` is valid `RD_LAT` cycles after the cycle in which `r`=1.

Ports (clock and reset first):
- `clk` input 1: single clock, all state updates on rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `req0` / `req1` input 1: access request, held until the matching `gnt`.
- `we0` / `we1` input 1: 1 = write, 0 = read.
- `addr0` / `addr1` input 8: memory address.
- `wdata0` / `wdata1` input 8: write data.
- `gnt0` / `gnt1` output 1: one-cycle pulse, command issued to memory this cycle.
- `rvalid0` / `rvalid1` output 1: one-cycle pulse, `rdata` holds that port's read result.
- `rdata` output 8: captured read data, shared by both ports.
- `busy` output 1: high whenever state != IDLE.
- `adr` output 8: to memory `adr`.
- `datain` output 8: to memory `datain`.
- `w` output 1: to memory `w`.
- `r` output 1: to memory `r`.
- `dataout` input 8: from memory `dataout`.

## Operation
State machine states: IDLE, CMD, RWAIT, RESP.

IDLE:
- If no `req` is high, stay in IDLE.
- If exactly one `req` is high, grant that port.
- If both are high, grant the port other than `last`, where `last` is the last-granted-port register. Reset value of `last` is 1, so port 0 wins the first tie.
- On a grant: latch the winner's `we`, `addr`, `wdata` and port id; set `last` to the winner; go to CMD.

CMD (exactly 1 cycle):
- `adr` = latched addr.
- Write: `datain` = latched wdata, `w`=1.
- Read: `r`=1.
- `gnt<port>`=1.
- Next state:
  - write: IDLE.
  - read with `RD_LAT`=0: capture `dataout` into `rdata` at the end of this cycle, go to RESP.
  - read with `RD_LAT`>=1: load the counter, go to RWAIT.

RWAIT:
- Lasts exactly `RD_LAT` cycles.
- `dataout` is captured into `rdata` at the end of the last RWAIT cycle.
- Then go to RESP.

RESP (1 cycle):
- `rvalid<port>`=1.
- `rdata` is held until the next capture.
- Next state is IDLE.

Output and state rules:
- `w` and `r` are never high together.
- Both are 0 in every state except CMD.
- `adr` and `datain` hold their last driven value outside CMD.
- At most one `gnt*` and at most one `rvalid*` is high in any cycle.
- A `gnt` never occurs while a read is outstanding (states RWAIT and RESP).
- Requests that arrive in a non-IDLE state wait; none are dropped or queued beyond the held `req`.
- The command is latched in IDLE, so input changes after the grant decision do not affect the issued command.
- A `req` that drops before its `gnt` may still be served once. This is a requester protocol violation; the arbiter does not detect it.

## Timing
Reset (`rst_n`=0 at a rising edge):
- State goes to IDLE; `last`=1; counter=0.
- All outputs become 0: `gnt*`, `rvalid*`, `rdata`, `busy`, `adr`, `datain`, `w`, `r`.

Cycle counts, with the `req` first sampled in IDLE at cycle T:
- `gnt` is asserted in cycle T+1.
- Write: the memory write happens in cycle T+1. The arbiter is back in IDLE at T+2, and a new grant can be made at T+2. A write occupies 2 cycles.
- Read: `rvalid` is asserted in cycle T+2+`RD_LAT`. IDLE is reached at T+3+`RD_LAT`.

Back-to-back operation:
- With both ports requesting continuously, grants strictly alternate 0,1,0,1.
- No port waits more than one foreign access.

Reset mid-operation:
- Reset applied in CMD, RWAIT or RESP aborts the access.
- No `rvalid` is produced for it, and `w`/`r` drop to 0 at that edge.

## Test plan
1. Hold `rst_n`=0 for 2 cycles with random inputs, including `req0`=`req1`=1 -> every output is 0 and `busy`=0. After release, the first tie is granted to port 0.
2. Port 0 write `addr0`=0x0A, `wdata0`=0xFF, then port 0 read 0x0A (`RD_LAT`=1):
   - Write: `gnt0`, `w`=1, `adr`=0x0A, `datain`=0xFF in a single cycle.
   - Read: `r`=1 in the CMD cycle; `rvalid0`=1 with `rdata`=0xFF two cycles after the `r` cycle.
3. Both ports held requesting; port 0 writes 0x55 to 0x00, port 1 writes 0x11 to 0x01 -> `gnt0` in cycle T+1, `gnt1` in cycle T+3. Readback returns 0x55 and 0x11.
4. Port 1 read of 0x01 in progress while `req0` rises during RWAIT -> `gnt0` comes no earlier than 2 cycles after `rvalid1`, i.e. from IDLE. `rvalid0` is never high during port 1's response.
5. `rst_n`=0 during RWAIT of a port 0 read -> `rvalid0` never asserts, `r`=`w`=0 and `busy`=0 after the edge. A subsequent tie is granted to port 0.
6. `RD_LAT` sweep 0 and 3, read of a preloaded 0x3C -> `rvalid` asserted at CMD+1 and CMD+4 respectively, with `rdata`=0x3C.
